video_timing_gen: RTL and testbench

- Raster timing source that drives the pixel generator.
- Produces pixel_cnt, line_cnt, video_on, h_sync and v_sync from programmable porch and sync parameters. Defaults are 640x480@60 on a 25.175 MHz rfr_clk.
- Adds an enable handshake so a frame is never truncated, plus line_start and frame_start strobes for downstream blocks.

---
 rtl/video_timing_gen.sv | 142 ++++++++++++++
 tb/tb_video_timing_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator with programmable porches/syncs and an enable handshake that always finishes the frame.
// Build with SYNC_DELAY_EN to delay sync, video_on and strobes by SYNC_DLY register stages.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int SYNC_DLY = 2
) (
  input  logic        rfr_clk,
  input  logic        reset,
  input  logic        en,
  output logic [11:0] pixel_cnt,
  output logic [11:0] line_cnt,
  output logic        video_on,
  output logic        h_sync,
  output logic        v_sync,
  output logic        line_start,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 4096 || V_TOTAL > 4096 ||
        H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_cfg
      $error("video_timing_gen: invalid timing parameters");
    end
  endgenerate

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t      state, state_nxt;
  logic [11:0] pix_nxt, line_nxt;
  logic        pix_wrap, frame_wrap, run_nxt;
  logic        von_nxt, hs_nxt, vs_nxt, ls_nxt, fs_nxt;
  logic        von_q, hs_q, vs_q, ls_q, fs_q;

  assign pix_wrap   = (pixel_cnt == H_LAST);
  assign frame_wrap = pix_wrap && (line_cnt == V_LAST);

  always_comb begin
    state_nxt = state;
    pix_nxt   = 12'd0;
    line_nxt  = 12'd0;
    if (state != IDLE) begin
      if (!pix_wrap) begin
        pix_nxt  = pixel_cnt + 12'd1;
        line_nxt = line_cnt;
      end else if (!frame_wrap) begin
        line_nxt = line_cnt + 12'd1;
      end
    end
    case (state)
      IDLE:     if (en) state_nxt = RUN;
      RUN:      if (!en) state_nxt = STOPPING;
      STOPPING: begin
        if (en)              state_nxt = RUN;
        else if (frame_wrap) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
    // Decode from next-state counters so the registered outputs line up with pixel_cnt/line_cnt.
    run_nxt = (state_nxt != IDLE);
    von_nxt = run_nxt && (pix_nxt < H_VIS) && (line_nxt < V_VIS);
    hs_nxt  = (run_nxt && pix_nxt >= HS_BEG && pix_nxt < HS_END) ? H_POL : ~H_POL;
    vs_nxt  = (run_nxt && line_nxt >= VS_BEG && line_nxt < VS_END) ? V_POL : ~V_POL;
    ls_nxt  = run_nxt && (pix_nxt == 12'd0);
    fs_nxt  = ls_nxt && (line_nxt == 12'd0);
  end

  always_ff @(posedge rfr_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pixel_cnt <= 12'd0;
      line_cnt  <= 12'd0;
      busy      <= 1'b0;
      von_q     <= 1'b0;
      hs_q      <= ~H_POL;
      vs_q      <= ~V_POL;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pixel_cnt <= pix_nxt;
      line_cnt  <= line_nxt;
      busy      <= run_nxt;
      von_q     <= von_nxt;
      hs_q      <= hs_nxt;
      vs_q      <= vs_nxt;
      ls_q      <= ls_nxt;
      fs_q      <= fs_nxt;
    end
  end

`ifdef SYNC_DELAY_EN
  generate
    if (SYNC_DLY == 0) begin : g_bad_dly
      $error("video_timing_gen: SYNC_DLY must be nonzero");
    end
  endgenerate

  localparam logic [4:0] DLY_RST = {~H_POL, ~V_POL, 3'b000};
  logic [4:0] dly_pipe [SYNC_DLY];

  always_ff @(posedge rfr_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_DLY; i++) dly_pipe[i] <= DLY_RST;
    end else begin
      dly_pipe[0] <= {hs_q, vs_q, von_q, ls_q, fs_q};
      for (int i = 1; i < SYNC_DLY; i++) dly_pipe[i] <= dly_pipe[i-1];
    end
  end

  assign {h_sync, v_sync, video_on, line_start, frame_start} = dly_pipe[SYNC_DLY-1];
`else
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign video_on    = von_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 15x8 raster (8+2+3+2 pixels, 4+1+2+1 lines).
// h_sync is configured active-high and v_sync active-low so both polarities are exercised.
module tb_video_timing_gen;
  localparam int HT = 15;
  localparam int VT = 8;

  logic        rfr_clk = 1'b0;
  logic        reset;
  logic        en;
  logic [11:0] pixel_cnt, line_cnt;
  logic        video_on, h_sync, v_sync, line_start, frame_start, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int k;
  int trk_err;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0), .SYNC_DLY(2)
  ) dut (
    .rfr_clk(rfr_clk), .reset(reset), .en(en),
    .pixel_cnt(pixel_cnt), .line_cnt(line_cnt), .video_on(video_on),
    .h_sync(h_sync), .v_sync(v_sync), .line_start(line_start),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 rfr_clk = ~rfr_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle while running; counters must follow the raster position k.
  task automatic adv();
    @(negedge rfr_clk);
    k++;
    if (pixel_cnt !== 12'(k % HT) || line_cnt !== 12'((k / HT) % VT)) trk_err++;
  endtask

  initial begin
    int bad, von_n, hs_n, vs_n, ls_n, fs_n, busy_low;
    reset = 1'b1; en = 1'b0; trk_err = 0; k = 0;

    repeat (3) @(negedge rfr_clk);
    check("rst_pix",  32'(pixel_cnt), 0);
    check("rst_line", 32'(line_cnt), 0);
    check("rst_von",  32'(video_on), 0);
    check("rst_hs",   32'(h_sync), 0);
    check("rst_vs",   32'(v_sync), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ls",   32'(line_start), 0);
    check("rst_fs",   32'(frame_start), 0);
    reset = 1'b0;

    bad = 0;
    repeat (20) begin
      @(negedge rfr_clk);
      if (pixel_cnt != 0 || line_cnt != 0 || video_on || h_sync !== 1'b0 ||
          v_sync !== 1'b1 || busy || line_start || frame_start) bad++;
    end
    check("idle_hold", bad, 0);

    // Start: one cycle later pixel (0,0) with all strobes.
    en = 1'b1;
    @(negedge rfr_clk); k = 0;
    check("start_pix",  32'(pixel_cnt), 0);
    check("start_line", 32'(line_cnt), 0);
    check("start_von",  32'(video_on), 1);
    check("start_ls",   32'(line_start), 1);
    check("start_fs",   32'(frame_start), 1);
    check("start_busy", 32'(busy), 1);

    von_n = 1; hs_n = 0; vs_n = 0; ls_n = 1; fs_n = 1;
    for (int i = 1; i < HT * VT; i++) begin
      adv();
      von_n += int'(video_on);
      hs_n  += int'(h_sync);
      vs_n  += int'(!v_sync);
      ls_n  += int'(line_start);
      fs_n  += int'(frame_start);
      case (k)
        7:   check("von_last", 32'(video_on), 1);
        8:   check("von_fall", 32'(video_on), 0);
        9:   check("hs_pre",   32'(h_sync), 0);
        10:  check("hs_rise",  32'(h_sync), 1);
        12:  check("hs_last",  32'(h_sync), 1);
        13:  check("hs_fall",  32'(h_sync), 0);
        14:  check("pix_max",  32'(pixel_cnt), 14);
        15:  begin
          check("wrap_line", 32'(line_cnt), 1);
          check("wrap_ls",   32'(line_start), 1);
          check("wrap_fs",   32'(frame_start), 0);
        end
        60:  check("von_line4", 32'(video_on), 0);
        74:  check("vs_pre",  32'(v_sync), 1);
        75:  check("vs_fall", 32'(v_sync), 0);
        104: check("vs_last", 32'(v_sync), 0);
        105: check("vs_rise", 32'(v_sync), 1);
        default: ;
      endcase
    end
    check("von_count", von_n, 32);
    check("hs_count",  hs_n, 24);
    check("vs_count",  vs_n, 30);
    check("ls_count",  ls_n, 8);
    check("fs_count",  fs_n, 1);
    adv();
    check("period_fs",   32'(frame_start), 1);
    check("period_line", 32'(line_cnt), 0);

    // Drop en at line 2 of frame 2: frame must finish before returning to IDLE.
    while (k < 150) adv();
    en = 1'b0;
    busy_low = 0;
    while (k < 239) begin adv(); busy_low += int'(!busy); end
    check("stop_busy_held", busy_low, 0);
    check("stop_last_pix",  32'(pixel_cnt), 14);
    check("stop_last_line", 32'(line_cnt), 7);
    check("trk_run1", trk_err, 0);
    @(negedge rfr_clk);
    check("stop_busy", 32'(busy), 0);
    check("stop_pix",  32'(pixel_cnt), 0);
    check("stop_line", 32'(line_cnt), 0);
    check("stop_von",  32'(video_on), 0);
    check("stop_fs",   32'(frame_start), 0);
    check("stop_hs",   32'(h_sync), 0);
    check("stop_vs",   32'(v_sync), 1);
    bad = 0;
    repeat (5) begin
      @(negedge rfr_clk);
      if (busy || pixel_cnt != 0 || line_start) bad++;
    end
    check("stop_idle_hold", bad, 0);

    // Reassert en while STOPPING: no disturbance, next frame on time.
    en = 1'b1;
    @(negedge rfr_clk); k = 0;
    check("re_start_fs", 32'(frame_start), 1);
    fs_n = 0; busy_low = 0;
    while (k < 119) begin
      adv();
      if (k == 30) en = 1'b0;
      if (k == 60) en = 1'b1;
      fs_n += int'(frame_start);
      busy_low += int'(!busy);
    end
    check("re_fs_none", fs_n, 0);
    check("re_busy", busy_low, 0);
    adv();
    check("re_period_fs", 32'(frame_start), 1);

    // en returns exactly on the wrap edge: must go to RUN with a seamless frame.
    while (k < 150) adv();
    en = 1'b0;
    while (k < 239) adv();
    en = 1'b1;
    adv();
    check("wrapen_fs",   32'(frame_start), 1);
    check("wrapen_busy", 32'(busy), 1);
    check("trk_run2", trk_err, 0);

    // Async reset mid-frame at pixel 11, line 5 (inside both sync windows).
    while (k < 326) adv();
    check("pre_rst_hs", 32'(h_sync), 1);
    check("pre_rst_vs", 32'(v_sync), 0);
    #2 reset = 1'b1;
    #1;
    check("arst_pix",  32'(pixel_cnt), 0);
    check("arst_line", 32'(line_cnt), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_von",  32'(video_on), 0);
    check("arst_hs",   32'(h_sync), 0);
    check("arst_vs",   32'(v_sync), 1);
    @(negedge rfr_clk);
    @(negedge rfr_clk);
    reset = 1'b0;
    @(negedge rfr_clk); k = 0;
    check("rerun_pix", 32'(pixel_cnt), 0);
    check("rerun_line", 32'(line_cnt), 0);
    check("rerun_fs",  32'(frame_start), 1);
    check("rerun_busy", 32'(busy), 1);
    repeat (3) adv();
    check("trk_final", trk_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
